// File: rtl/sysx_slave_endpoint.sv
// sysX v1 peripheral endpoint: oversamples the master's bus, assembles 4-byte beats
// into a receive FIFO and returns a transmit word on MISO.
module sysx_slave_endpoint #(
  parameter logic [1:0]  pSelectID  = 2'h1,
  parameter int unsigned pFifoDepth = 4
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iBusClock,
  input  logic [1:0]  iBusSelect,
  input  logic [7:0]  iBusMOSI,
  output logic [7:0]  oBusMISO,
  output logic        oBusInterrupt,
  output logic [31:0] oRxData,
  output logic        oRxValid,
  input  logic        iRxReady,
  input  logic [31:0] iTxData,
  input  logic        iTxValid,
  output logic        oTxReady,
  output logic        oOverflow,
  output logic        oAbort,
  input  logic        iClearStatus
);

  localparam int unsigned   cAddrW  = $clog2(pFifoDepth);
  localparam logic [cAddrW:0] cFull = (cAddrW + 1)'(pFifoDepth);
  localparam logic [31:0]   cFiller = 32'h0BADC0DE;

  logic              rClkS1, rClkS2, rClkS3;
  logic [1:0]        rSelS1, rSelS2;
  logic [7:0]        rMosiS1, rMosiS2;
  logic [1:0]        rSyncValid;
  logic              rArmed, rSelPrev;
  logic [1:0]        rByteCount;
  logic [23:0]       rAssemble;
  logic [31:0]       rTxShift, rTxHold;
  logic [31:0]       rMem [pFifoDepth];
  logic [cAddrW-1:0] rWrPtr, rRdPtr;
  logic [cAddrW:0]   rCount;

  logic              tick, selected, selStart, wordDone, snapshot;
  logic              txLoad, pop, push, dropWord, abortSet;
  logic [31:0]       pushWord, txShiftNext, headNext;
  logic              txFullNext;
  logic [1:0]        byteCountNext;
  logic [cAddrW-1:0] wrPtrNext, rdPtrNext;
  logic [cAddrW:0]   countNext;
  logic [7:0]        misoNext;

  always_comb begin
    tick          = rClkS2 & ~rClkS3;
    selected      = rArmed && (rSelS2 == pSelectID);
    selStart      = selected && !rSelPrev;
    wordDone      = selected && tick && (rByteCount == 2'd3);
    snapshot      = selStart || wordDone;
    txLoad        = iTxValid && oTxReady;
    pop           = oRxValid && iRxReady;
    push          = wordDone && ((rCount != cFull) || pop);
    dropWord      = wordDone && (rCount == cFull) && !pop;
    abortSet      = !selected && (rByteCount != 2'd0);
    pushWord      = {rMosiS2, rAssemble};

    byteCountNext = '0;
    if (selected) byteCountNext = tick ? rByteCount + 2'd1 : rByteCount;

    txShiftNext = rTxShift;
    txFullNext  = oBusInterrupt;
    if (snapshot) begin
      txShiftNext = oBusInterrupt ? rTxHold : cFiller;
      txFullNext  = 1'b0;
    end else if (txLoad) begin
      txFullNext  = 1'b1;
    end

    misoNext  = selected ? txShiftNext[{byteCountNext, 3'b000} +: 8] : 8'h00;

    wrPtrNext = rWrPtr + cAddrW'(push);
    rdPtrNext = rRdPtr + cAddrW'(pop);
    countNext = rCount + (cAddrW + 1)'(push) - (cAddrW + 1)'(pop);

    // Head is registered; bypass the word being written when it lands at the new head.
    headNext = oRxData;
    if (countNext != '0) begin
      if (push && (rWrPtr == rdPtrNext)) headNext = pushWord;
      else                               headNext = rMem[rdPtrNext];
    end
  end

  always_ff @(posedge iClock) begin
    if (push) rMem[rWrPtr] <= pushWord;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      rClkS1        <= 1'b0;
      rClkS2        <= 1'b0;
      rClkS3        <= 1'b0;
      rSelS1        <= '0;
      rSelS2        <= '0;
      rMosiS1       <= '0;
      rMosiS2       <= '0;
      rSyncValid    <= '0;
      rArmed        <= 1'b0;
      rSelPrev      <= 1'b0;
      rByteCount    <= '0;
      rAssemble     <= '0;
      rTxShift      <= '0;
      rTxHold       <= '0;
      rWrPtr        <= '0;
      rRdPtr        <= '0;
      rCount        <= '0;
      oBusMISO      <= 8'h00;
      oBusInterrupt <= 1'b0;
      oRxData       <= '0;
      oRxValid      <= 1'b0;
      oTxReady      <= 1'b1;
      oOverflow     <= 1'b0;
      oAbort        <= 1'b0;
    end else begin
      rClkS1     <= iBusClock;
      rClkS2     <= rClkS1;
      rClkS3     <= rClkS2;
      rSelS1     <= iBusSelect;
      rSelS2     <= rSelS1;
      rMosiS1    <= iBusMOSI;
      rMosiS2    <= rMosiS1;
      // Select zeros left in the synchroniser by reset must not count as an idle bus.
      rSyncValid <= {rSyncValid[0], 1'b1};
      if (rSyncValid[1] && (rSelS2 != pSelectID)) rArmed <= 1'b1;
      rSelPrev   <= selected;

      rByteCount <= byteCountNext;
      if (selected && tick && (rByteCount != 2'd3))
        rAssemble[{rByteCount, 3'b000} +: 8] <= rMosiS2;

      rTxShift      <= txShiftNext;
      if (txLoad) rTxHold <= iTxData;
      oBusInterrupt <= txFullNext;
      oTxReady      <= ~txFullNext;
      oBusMISO      <= misoNext;

      rWrPtr   <= wrPtrNext;
      rRdPtr   <= rdPtrNext;
      rCount   <= countNext;
      oRxValid <= (countNext != '0);
      oRxData  <= headNext;

      if (dropWord)          oOverflow <= 1'b1;
      else if (iClearStatus) oOverflow <= 1'b0;
      if (abortSet)          oAbort <= 1'b1;
      else if (iClearStatus) oAbort <= 1'b0;
    end
  end

endmodule
